// File: rtl/vga_rect_arbiter.sv
// vga_rect_arbiter: round-robin share of the vga_adapter write port among
// NUM_REQ rectangle-drawing clients. The winner's rectangle is latched and
// emitted one pixel per clock, row-major.
// Optional build macro: RECT_CLIP_EN (suppress plot for off-screen pixels).
module vga_rect_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int DIM_W    = 5,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [8*NUM_REQ-1:0]     rect_x,
  input  logic [7*NUM_REQ-1:0]     rect_y,
  input  logic [DIM_W*NUM_REQ-1:0] rect_w,
  input  logic [DIM_W*NUM_REQ-1:0] rect_h,
  input  logic [6*NUM_REQ-1:0]     rect_colour,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic [5:0]               colour,
  output logic                     plot
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef RECT_CLIP_EN
  localparam int XFW = 9;  // full-width sums are needed for the clip test
  localparam int YFW = 8;
`else
  localparam int XFW = 8;  // only the truncated coordinate is ever used
  localparam int YFW = 7;
`endif
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr, win, pick;
  logic [7:0]       lx0, pick_x;
  logic [6:0]       ly0, pick_y;
  logic [DIM_W-1:0] lw, lh, pick_w, pick_h, col, row, ncol, nrow;
  logic [5:0]       lcol, pick_c;
  logic             found, last_col, last_pix, vis;
  logic [XFW-1:0]   xf;
  logic [YFW-1:0]   yf;
  int               idx;

  // Round-robin pick: first requester at or above rr_ptr, wrapping; mux its fields.
  always_comb begin
    pick   = '0;
    found  = 1'b0;
    idx    = 0;
    pick_x = '0;
    pick_y = '0;
    pick_w = '0;
    pick_h = '0;
    pick_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == pick) begin
        pick_x = rect_x[8*i +: 8];
        pick_y = rect_y[7*i +: 7];
        pick_w = rect_w[DIM_W*i +: DIM_W];
        pick_h = rect_h[DIM_W*i +: DIM_W];
        pick_c = rect_colour[6*i +: 6];
      end
    end
  end

  // Next pixel position: (0,0) when leaving LOAD, otherwise row-major step.
  always_comb begin
    last_col = (col == lw - DIM_W'(1));
    last_pix = last_col && (row == lh - DIM_W'(1));
    if (state == LOAD) begin
      ncol = '0;
      nrow = '0;
    end else if (last_col) begin
      ncol = '0;
      nrow = row + DIM_W'(1);
    end else begin
      ncol = col + DIM_W'(1);
      nrow = row;
    end
    xf = XFW'(lx0) + XFW'(ncol);
    yf = YFW'(ly0) + YFW'(nrow);
`ifdef RECT_CLIP_EN
    vis = (xf < XFW'(SCREEN_W)) && (yf < YFW'(SCREEN_H));
`else
    vis = 1'b1;
`endif
  end

  // Arbitration / scan FSM with registered outputs; pixel outputs hold unless emitting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      win    <= '0;
      lx0    <= '0;
      ly0    <= '0;
      lw     <= '0;
      lh     <= '0;
      lcol   <= '0;
      col    <= '0;
      row    <= '0;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      plot <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          win   <= pick;
          lx0   <= pick_x;
          ly0   <= pick_y;
          lw    <= pick_w;
          lh    <= pick_h;
          lcol  <= pick_c;
          gnt   <= ONE << pick;
          busy  <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
          col    <= '0;
          row    <= '0;
          if (lw == '0 || lh == '0) begin
            done  <= ONE << win;
            state <= DONE;
          end else begin
            x      <= xf[7:0];
            y      <= yf[6:0];
            colour <= lcol;
            plot   <= vis;
            state  <= DRAW;
          end
        end
        DRAW: begin
          if (last_pix) begin
            done  <= ONE << win;
            state <= DONE;
          end else begin
            col    <= ncol;
            row    <= nrow;
            x      <= xf[7:0];
            y      <= yf[6:0];
            colour <= lcol;
            plot   <= vis;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
